piso_scan_ctrl: RTL and testbench
=================================

PISO_SCAN_CTRL -- requirements
Module: piso_scan_ctrl

Interface
REQ-001 Parameter N_DEV, default 1: number of cascaded 74LS165-style shift registers; NBITS = 8*N_DEV.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per shift-clock half-period; legal range 3..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one scan; sampled only in IDLE.
REQ-006 cont  input  1  continuous mode; in IDLE it acts as start every cycle.
REQ-007 busy  output  1  high whenever state != IDLE.
REQ-008 data_out  output  NBITS  last captured word; first serial bit captured lands in the MSB.
REQ-009 data_valid  output  1  data_out holds an unacknowledged word.
REQ-010 data_ready  input  1  consumer accepts data_out when data_valid=1.
REQ-011 overrun  output  1  one-cycle pulse: a new word overwrote an unacknowledged one.
REQ-012 sr_shld  output  1  shift/load to the register chain, 0 = parallel load.
REQ-013 sr_clk  output  1  shift clock to the chain; the chain shifts on its rising edge.
REQ-014 sr_clk_inh  output  1  clock inhibit to the chain, 1 = inhibited.
REQ-015 sr_qh  input  1  serial output QH of the last device in the chain.

Function
REQ-016 sr_qh SHALL pass through a 2-flop synchronizer before use; the sampled value is the synchronizer output.
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT_LO and SHIFT_HI; LOAD, SHIFT_LO and SHIFT_HI each last exactly CLK_DIV clk cycles, with the tick counter restarting on every state entry.
REQ-018 IDLE: if start|cont, go to LOAD on the next edge; otherwise stay. sr_shld=1, sr_clk=0, sr_clk_inh=1.
REQ-019 LOAD: sr_shld=0, sr_clk=0, sr_clk_inh=1; the bit counter clears to 0; then go to SHIFT_LO.
REQ-020 SHIFT_LO: sr_shld=1, sr_clk=0, sr_clk_inh=0; on the final cycle, shift the synchronized QH into the LSB of the capture register and increment the bit counter.
REQ-021 After SHIFT_LO: if the bit counter has reached NBITS, go to IDLE and transfer the capture register to data_out; otherwise go to SHIFT_HI.
REQ-022 SHIFT_HI: sr_shld=1, sr_clk=1, sr_clk_inh=0; then go to SHIFT_LO.
REQ-023 Scan length SHALL be 2*NBITS*CLK_DIV cycles; data_valid rises 2*NBITS*CLK_DIV+1 cycles after the cycle in which start is sampled.
REQ-024 sr_clk SHALL produce exactly NBITS-1 rising edges per scan, with no glitches; all sr_* outputs SHALL come directly from flops.
REQ-025 Handshake: data_valid is set on transfer and cleared on the edge where data_valid & data_ready; if both events occur in the same cycle, data_valid stays 1.
REQ-026 If a transfer occurs while data_valid=1 and data_ready=0, data_out SHALL be overwritten and overrun pulses for that one cycle.
REQ-027 start asserted while busy SHALL be ignored, with no queuing.
REQ-028 With cont=1, IDLE SHALL last exactly one cycle between scans.
REQ-029 data_out SHALL change only on transfer.

Reset
REQ-030 On rst_n=0, with no clock required, all state SHALL clear: state=IDLE, busy=0, data_valid=0, overrun=0, data_out=0, sr_shld=1, sr_clk=0, sr_clk_inh=1, counters and synchronizer 0.
REQ-031 Reset mid-scan SHALL abort the scan; the partial capture is discarded.
REQ-032 After rst_n deasserts, the first scan SHALL start only on a start or cont sampled at a rising edge.

Structure
REQ-033 Package piso_scan_pkg SHALL hold the state enum, CLK_DIV width constant, and counter-width function (clog2 of NBITS+1).
REQ-034 Sub-module piso_tick_gen SHALL generate the per-state CLK_DIV cycle count and an end-of-state strobe, restartable on state entry; everything else SHALL stay in piso_scan_ctrl.

Verification
REQ-035 Test 1: N_DEV=1, CLK_DIV=4, chain model loaded with 0xA5, one start pulse -> data_out=0xA5, data_valid rises 65 cycles after start, 7 sr_clk rising edges.
REQ-036 Test 2: N_DEV=2, chain loaded with 0x1234 -> data_out=0x1234 and busy high for exactly 128 cycles.
REQ-037 Test 3: cont=1, data_ready=0, two scans of 0x3C then 0xC3 -> overrun pulses once at the second transfer and data_out=0xC3.
REQ-038 Test 4: data_ready held 1 at transfer -> data_valid stays 1, then clears the cycle after the next accept; start during busy -> ignored, exactly one scan.
REQ-039 Test 5: rst_n asserted mid-SHIFT_HI -> same-cycle sr_clk=0, sr_shld=1, sr_clk_inh=1, data_valid=0; after release, idle until start.

Source files
------------

// File: rtl/piso_scan_pkg.sv
// Shared types and sizing helpers for the PISO scan controller.
package piso_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI
    } state_t;

    // Wide enough for CLK_DIV up to 255
    localparam int DIV_W = 8;

    function automatic int cnt_w(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/piso_scan_ctrl_if.sv
// Control, capture handshake and shift-register chain pins of the scan controller.
// slave = controller side, master = consumer/chain side.
interface piso_scan_ctrl_if #(parameter int NBITS = 8);
    logic             start;
    logic             cont;
    logic             busy;
    logic [NBITS-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             sr_shld;
    logic             sr_clk;
    logic             sr_clk_inh;
    logic             sr_qh;

    modport slave (
        input  start, cont, data_ready, sr_qh,
        output busy, data_out, data_valid, overrun, sr_shld, sr_clk, sr_clk_inh
    );

    modport master (
        output start, cont, data_ready, sr_qh,
        input  busy, data_out, data_valid, overrun, sr_shld, sr_clk, sr_clk_inh
    );
endinterface

// File: rtl/piso_tick_gen.sv
// Per-state cycle counter: tick_end strobes combinationally on the CLK_DIV-th cycle of a state.
// No backpressure; held at zero while restart is high so the next state starts a full period.
module piso_tick_gen
    import piso_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick_end
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick_end = !restart && (cnt == LAST);
endmodule

// File: rtl/piso_scan_ctrl.sv
// Scans a chain of 74LS165-style PISO registers into data_out; a scan takes 2*NBITS*CLK_DIV cycles.
// Valid/ready output; an unaccepted word is overwritten on the next transfer and flagged by overrun.
module piso_scan_ctrl
    import piso_scan_pkg::*;
#(
    parameter int N_DEV   = 1,
    parameter int CLK_DIV = 4
) (
    input logic            clk,
    input logic            rst_n,
    piso_scan_ctrl_if.slave bus
);
    localparam int NBITS = 8 * N_DEV;
    localparam int CW    = cnt_w(NBITS);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [NBITS-2:0] cap;
    logic [1:0]       sync;
    logic             tick_end;

    logic             busy_r, dv_r, ovr_r, shld_r, sclk_r, inh_r;
    logic [NBITS-1:0] dout_r;

    piso_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state == ST_IDLE),
        .tick_end (tick_end)
    );

    // Chain pins are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cap     <= '0;
            sync    <= '0;
            busy_r  <= 1'b0;
            dv_r    <= 1'b0;
            ovr_r   <= 1'b0;
            dout_r  <= '0;
            shld_r  <= 1'b1;
            sclk_r  <= 1'b0;
            inh_r   <= 1'b1;
        end else begin
            sync  <= {sync[0], bus.sr_qh};
            ovr_r <= 1'b0;
            if (dv_r && bus.data_ready) dv_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start || bus.cont) begin
                        state  <= ST_LOAD;
                        busy_r <= 1'b1;
                        shld_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                    if (tick_end) begin
                        state  <= ST_SHIFT_LO;
                        shld_r <= 1'b1;
                        inh_r  <= 1'b0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick_end) begin
                        cap     <= {cap[NBITS-3:0], sync[1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(NBITS - 1)) begin
                            // Transfer wins over a same-cycle accept
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                            inh_r  <= 1'b1;
                            dout_r <= {cap, sync[1]};
                            dv_r   <= 1'b1;
                            ovr_r  <= dv_r && !bus.data_ready;
                        end else begin
                            state  <= ST_SHIFT_HI;
                            sclk_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick_end) begin
                        state  <= ST_SHIFT_LO;
                        sclk_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data_out   = dout_r;
    assign bus.data_valid = dv_r;
    assign bus.overrun    = ovr_r;
    assign bus.sr_shld    = shld_r;
    assign bus.sr_clk     = sclk_r;
    assign bus.sr_clk_inh = inh_r;
endmodule

// File: tb/tb_piso_scan_ctrl.sv
// Bench: two controllers (1 and 2 devices) driving behavioural 74LS165 chains, directed plus random scans.
module tb_piso_scan_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    piso_scan_ctrl_if #(.NBITS(8))  i1();
    piso_scan_ctrl_if #(.NBITS(16)) i2();

    piso_scan_ctrl #(.N_DEV(1), .CLK_DIV(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    piso_scan_ctrl #(.N_DEV(2), .CLK_DIV(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

    // Chain models: parallel load while SH/LD low, shift toward QH on sr_clk rise when enabled
    logic [7:0]  ch1 = '0, ld1 = '0;
    logic [15:0] ch2 = '0, ld2 = '0;
    always @(negedge i1.sr_shld or posedge i1.sr_clk)
        if (!i1.sr_shld) ch1 <= ld1;
        else if (!i1.sr_clk_inh) ch1 <= {ch1[6:0], 1'b0};
    always @(negedge i2.sr_shld or posedge i2.sr_clk)
        if (!i2.sr_shld) ch2 <= ld2;
        else if (!i2.sr_clk_inh) ch2 <= {ch2[14:0], 1'b0};
    assign i1.sr_qh = ch1[7];
    assign i2.sr_qh = ch2[15];

    int edges1 = 0;
    always @(posedge i1.sr_clk) edges1++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    int          lat, nb, novr, gap;
    logic        hit, mvalid, movr, xfer, rdy;
    logic [15:0] mdata;
    logic [31:0] word;

    initial begin
        i1.start = 0; i1.cont = 0; i1.data_ready = 0;
        i2.start = 0; i2.cont = 0; i2.data_ready = 0;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy",  i1.busy,       0);
        chk("rst_dv",    i1.data_valid, 0);
        chk("rst_ovr",   i1.overrun,    0);
        chk("rst_dout",  i1.data_out,   0);
        chk("rst_shld",  i1.sr_shld,    1);
        chk("rst_sclk",  i1.sr_clk,     0);
        chk("rst_inh",   i1.sr_clk_inh, 1);
        chk("rst_dout2", i2.data_out,   0);
        repeat (3) cyc1();
        rst_n = 1'b1;
        repeat (5) cyc1();
        chk("idle_busy1", i1.busy, 0);
        chk("idle_busy2", i2.busy, 0);

        // Test 1: single 8-bit scan
        ld1 = 8'hA5; edges1 = 0; lat = 0;
        i1.start = 1;
        for (int k = 1; k <= 200; k++) begin
            cyc1();
            if (k == 1) i1.start = 0;
            if (i1.data_valid) begin lat = k; break; end
        end
        chk("t1_latency", lat, 65);
        chk("t1_data",    i1.data_out, 8'hA5);
        chk("t1_edges",   edges1, 7);

        // Test 2: two cascaded devices
        ld2 = 16'h1234; nb = 0; lat = 0;
        i2.start = 1;
        for (int k = 1; k <= 400; k++) begin
            cyc1();
            if (k == 1) i2.start = 0;
            if (i2.busy) nb++;
            if (i2.data_valid) begin lat = k; break; end
        end
        chk("t2_data",    i2.data_out, 16'h1234);
        chk("t2_busy",    nb, 128);
        chk("t2_latency", lat, 129);

        // Test 4: transfer coinciding with accept, start during busy ignored
        word = $urandom; ld1 = word[7:0]; edges1 = 0;
        i1.start = 1;
        for (int k = 1; k <= 90; k++) begin
            cyc1();
            case (k)
                1:  i1.start = 0;
                10: i1.start = 1;
                11: i1.start = 0;
                64: begin
                    chk("t4_hold", i1.data_out, 8'hA5);
                    i1.data_ready = 1;
                end
                65: begin
                    chk("t4_dv_stays", i1.data_valid, 1);
                    chk("t4_data",     i1.data_out, word[7:0]);
                    chk("t4_no_ovr",   i1.overrun, 0);
                    chk("t4_idle",     i1.busy, 0);
                end
                66: chk("t4_dv_clr", i1.data_valid, 0);
                default: ;
            endcase
        end
        chk("t4_one_scan", i1.busy, 0);
        chk("t4_edges",    edges1, 7);
        chk("t4_dout_kept", i1.data_out, word[7:0]);

        // Test 3: continuous mode with no consumer
        i1.data_ready = 0; ld1 = 8'h3C; novr = 0;
        i1.cont = 1;
        for (int k = 1; k <= 140; k++) begin
            cyc1();
            if (i1.overrun) novr++;
            case (k)
                5:   ld1 = 8'hC3;
                65: begin
                    chk("t3_data1", i1.data_out, 8'h3C);
                    chk("t3_dv1",   i1.data_valid, 1);
                    chk("t3_ovr1",  i1.overrun, 0);
                    chk("t3_gap",   i1.busy, 0);
                end
                66:  chk("t3_restart", i1.busy, 1);
                100: i1.cont = 0;
                130: begin
                    chk("t3_ovr2",  i1.overrun, 1);
                    chk("t3_data2", i1.data_out, 8'hC3);
                end
                default: ;
            endcase
        end
        chk("t3_ovr_count", novr, 1);
        chk("t3_stopped",   i1.busy, 0);

        // Randomized scans on the 16-bit chain against a word-level handshake model
        mvalid = 1'b1; mdata = 16'h1234;
        for (int it = 0; it < 6; it++) begin
            word = $urandom; ld2 = word[15:0];
            i2.data_ready = 0;
            gap = $urandom_range(0, 3);
            repeat (gap) cyc1();
            i2.start = 1;
            i2.data_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < 132; k++) begin
                if (k > 0) begin
                    i2.start      = (k < 100) && ($urandom_range(0, 15) == 0);
                    i2.data_ready = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                rdy  = i2.data_ready;
                xfer = (k == 128);
                movr = xfer && mvalid && !rdy;
                if (xfer) begin
                    mvalid = 1'b1;
                    mdata  = word[15:0];
                end else if (mvalid && rdy) begin
                    mvalid = 1'b0;
                end
                #1;
                chk("rnd_dv",   i2.data_valid, mvalid);
                chk("rnd_ovr",  i2.overrun, movr);
                chk("rnd_data", i2.data_out, mdata);
                chk("rnd_busy", i2.busy, k < 128);
            end
        end
        i2.start = 0; i2.data_ready = 0;

        // Test 5: reset during the shift-clock high phase
        i1.data_ready = 0; edges1 = 0; hit = 0;
        ld1 = 8'h5A;
        i1.start = 1;
        for (int k = 1; k <= 100; k++) begin
            cyc1();
            if (k == 1) i1.start = 0;
            if (i1.sr_clk) begin hit = 1; break; end
        end
        chk("t5_in_hi", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_sclk", i1.sr_clk,     0);
        chk("t5_shld", i1.sr_shld,    1);
        chk("t5_inh",  i1.sr_clk_inh, 1);
        chk("t5_dv",   i1.data_valid, 0);
        chk("t5_busy", i1.busy,       0);
        chk("t5_dout", i1.data_out,   0);
        #2 rst_n = 1'b1;
        repeat (10) cyc1();
        chk("t5_idle_busy", i1.busy,    0);
        chk("t5_idle_shld", i1.sr_shld, 1);
        chk("t5_edges",     edges1,     1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
